// File: rtl/cand_checker.sv
// Candidate legality checker: scans the row, column and 3x3 box peers of one cell
// through a synchronous grid-memory read port and reports whether the digit is legal.
module cand_checker #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_row,
  input  logic [3:0]        i_col,
  input  logic [DATA_W-1:0] i_candidate,
  output logic              o_rden,
  output logic [ADDR_W-1:0] o_rdaddr,
  input  logic [DATA_W-1:0] i_rddata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_valid
);

  localparam int unsigned K_W = 5;
  localparam logic [K_W-1:0] K_LAST = K_W'(26);
  localparam logic [3:0] MAX_IDX = 4'd8;
  localparam logic [DATA_W-1:0] MAX_DIGIT = DATA_W'(9);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t r_state, w_nxt_state;

  logic [K_W-1:0]    r_k, w_nxt_k;
  logic [3:0]        r_row, w_nxt_row;
  logic [3:0]        r_col, w_nxt_col;
  logic [DATA_W-1:0] r_cand, w_nxt_cand;
  logic              r_rden, w_nxt_rden;
  logic [ADDR_W-1:0] r_rdaddr, w_nxt_rdaddr;
  logic              r_iss_self, w_nxt_iss_self;
  logic              r_iss_last, w_nxt_iss_last;
  logic              r_cmp_vld, w_nxt_cmp_vld;
  logic              r_cmp_self, w_nxt_cmp_self;
  logic              r_cmp_last, w_nxt_cmp_last;
  logic              r_done, w_nxt_done;
  logic              r_valid, w_nxt_valid;
  logic              r_busy, w_nxt_busy;

  logic              w_issue;
  logic [3:0]        w_iss_row, w_iss_col;
  logic [K_W-1:0]    w_iss_k;
  logic [ADDR_W-1:0] w_peer_addr;
  logic              w_bad_req;
  logic              w_conflict;

  // Top-left row/column of the 3x3 box containing index x
  function automatic logic [3:0] box_base(input logic [3:0] x);
    case (x)
      4'd0, 4'd1, 4'd2: box_base = 4'd0;
      4'd3, 4'd4, 4'd5: box_base = 4'd3;
      default:          box_base = 4'd6;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
    cell_addr = ADDR_W'(row) * ADDR_W'(9) + ADDR_W'(col);
  endfunction

  // Peer k: 0..8 row, 9..17 column, 18..26 box (j/3, j%3 by lookup)
  function automatic logic [ADDR_W-1:0] peer_addr(input logic [3:0] row, input logic [3:0] col,
                                                  input logic [K_W-1:0] k);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] j;
    logic [3:0] jd;
    logic [3:0] jm;
    r  = row;
    c  = col;
    j  = 4'd0;
    jd = 4'd0;
    jm = 4'd0;
    if (k < K_W'(9)) begin
      c = 4'(k);
    end else if (k < K_W'(18)) begin
      r = 4'(k - K_W'(9));
    end else begin
      j = 4'(k - K_W'(18));
      case (j)
        4'd0: begin jd = 4'd0; jm = 4'd0; end
        4'd1: begin jd = 4'd0; jm = 4'd1; end
        4'd2: begin jd = 4'd0; jm = 4'd2; end
        4'd3: begin jd = 4'd1; jm = 4'd0; end
        4'd4: begin jd = 4'd1; jm = 4'd1; end
        4'd5: begin jd = 4'd1; jm = 4'd2; end
        4'd6: begin jd = 4'd2; jm = 4'd0; end
        4'd7: begin jd = 4'd2; jm = 4'd1; end
        default: begin jd = 4'd2; jm = 4'd2; end
      endcase
      r = box_base(row) + jd;
      c = box_base(col) + jm;
    end
    peer_addr = cell_addr(r, c);
  endfunction

  assign w_bad_req  = (i_candidate == '0) || (i_candidate > MAX_DIGIT) ||
                      (i_row > MAX_IDX) || (i_col > MAX_IDX);
  assign w_conflict = r_cmp_vld && !r_cmp_self && (i_rddata == r_cand);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  // Next state, read issue and result
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_k        = r_k;
    w_nxt_row      = r_row;
    w_nxt_col      = r_col;
    w_nxt_cand     = r_cand;
    w_nxt_done     = 1'b0;
    w_nxt_valid    = r_valid;
    w_issue        = 1'b0;
    w_iss_row      = r_row;
    w_iss_col      = r_col;
    w_iss_k        = r_k;
    w_nxt_rden     = 1'b0;
    w_nxt_rdaddr   = '0;
    w_nxt_iss_self = 1'b0;
    w_nxt_iss_last = 1'b0;
    w_peer_addr    = '0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_row   = i_row;
          w_nxt_col   = i_col;
          w_nxt_cand  = i_candidate;
          w_nxt_valid = 1'b0;
          if (w_bad_req) begin
            w_nxt_state = S_DONE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = S_SCAN;
            w_issue     = 1'b1;
            w_iss_row   = i_row;
            w_iss_col   = i_col;
            w_iss_k     = '0;
            w_nxt_k     = K_W'(1);
          end
        end
      end
      S_SCAN: begin
        if (w_conflict) begin
          w_nxt_state = S_DONE;
          w_nxt_done  = 1'b1;
          w_nxt_valid = 1'b0;
        end else if (r_cmp_vld && r_cmp_last) begin
          w_nxt_state = S_DONE;
          w_nxt_done  = 1'b1;
          w_nxt_valid = 1'b1;
        end else if (r_k <= K_LAST) begin
          w_issue = 1'b1;
          w_nxt_k = r_k + K_W'(1);
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_k     = '0;
      end
      default: w_nxt_state = S_IDLE;
    endcase

    if (w_issue) begin
      w_peer_addr    = peer_addr(w_iss_row, w_iss_col, w_iss_k);
      w_nxt_rden     = 1'b1;
      w_nxt_rdaddr   = w_peer_addr;
      w_nxt_iss_self = (w_peer_addr == cell_addr(w_iss_row, w_iss_col));
      w_nxt_iss_last = (w_iss_k == K_LAST);
    end
  end

  // Reads in flight are dropped once the scan is leaving SCAN
  assign w_nxt_cmp_vld  = r_rden && (w_nxt_state == S_SCAN);
  assign w_nxt_cmp_self = r_iss_self;
  assign w_nxt_cmp_last = r_iss_last;
  assign w_nxt_busy     = (w_nxt_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_cand     <= '0;
      r_rden     <= 1'b0;
      r_rdaddr   <= '0;
      r_iss_self <= 1'b0;
      r_iss_last <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_cmp_self <= 1'b0;
      r_cmp_last <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_k        <= w_nxt_k;
      r_row      <= w_nxt_row;
      r_col      <= w_nxt_col;
      r_cand     <= w_nxt_cand;
      r_rden     <= w_nxt_rden;
      r_rdaddr   <= w_nxt_rdaddr;
      r_iss_self <= w_nxt_iss_self;
      r_iss_last <= w_nxt_iss_last;
      r_cmp_vld  <= w_nxt_cmp_vld;
      r_cmp_self <= w_nxt_cmp_self;
      r_cmp_last <= w_nxt_cmp_last;
      r_done     <= w_nxt_done;
      r_valid    <= w_nxt_valid;
      r_busy     <= w_nxt_busy;
    end
  end

  assign o_rden   = r_rden;
  assign o_rdaddr = r_rdaddr;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_valid  = r_valid;

endmodule

// File: tb/tb_cand_checker.sv
// Directed bench for cand_checker with a synchronous grid memory model.
module tb_cand_checker;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_row;
  logic [3:0] i_col;
  logic [3:0] i_candidate;
  logic       o_rden;
  logic [6:0] o_rdaddr;
  logic [3:0] i_rddata;
  logic       o_busy;
  logic       o_done;
  logic       o_valid;

  logic [3:0] mem [81];

  int checks;
  int failures;

  int done_cyc, valid_at_done, busy_at_done, busy_after, valid_after;
  int rden_cnt, first_rd, last_rd, addr_zero_bad;
  int got_addr[$];

  int exp_addr_44[27] = '{36, 37, 38, 39, 40, 41, 42, 43, 44,
                          4, 13, 22, 31, 40, 49, 58, 67, 76,
                          30, 31, 32, 39, 40, 41, 48, 49, 50};

  cand_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_row       (i_row),
    .i_col       (i_col),
    .i_candidate (i_candidate),
    .o_rden      (o_rden),
    .o_rdaddr    (o_rdaddr),
    .i_rddata    (i_rddata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_valid     (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grid memory: data valid one cycle after the read request
  always @(posedge clk) begin
    if (o_rden) i_rddata <= mem[o_rdaddr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 81; i++) mem[i] = 4'd0;
  endtask

  // Accept one request, then trace outputs cycle by cycle until one cycle after o_done
  task automatic run_req(input logic [3:0] row, input logic [3:0] col, input logic [3:0] cand,
                         input int busy_start_at);
    done_cyc = 0; valid_at_done = -1; busy_at_done = -1; busy_after = -1; valid_after = -1;
    rden_cnt = 0; first_rd = 0; last_rd = 0; addr_zero_bad = 0;
    got_addr.delete();
    @(negedge clk);
    i_row = row; i_col = col; i_candidate = cand; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_row = 4'd0; i_col = 4'd0; i_candidate = 4'd1;
    for (int n = 1; n <= 40; n++) begin
      if (o_rden) begin
        rden_cnt++;
        if (first_rd == 0) first_rd = n;
        last_rd = n;
        got_addr.push_back(int'(o_rdaddr));
      end else if (o_rdaddr != 7'd0) begin
        addr_zero_bad++;
      end
      if (done_cyc != 0 && n == done_cyc + 1) begin
        busy_after  = int'(o_busy);
        valid_after = int'(o_valid);
        break;
      end
      if (o_done && done_cyc == 0) begin
        done_cyc      = n;
        valid_at_done = int'(o_valid);
        busy_at_done  = int'(o_busy);
      end
      i_start = (n == busy_start_at);
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    if (done_cyc == 0) chk("done_timeout", 0, 1);
  endtask

  function automatic int addr_errs(input int n);
    int e;
    e = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got_addr.size()) e++;
      else if (got_addr[i] != exp_addr_44[i]) e++;
    end
    return e;
  endfunction

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; i_start = 1'b0; i_row = 4'd0; i_col = 4'd0; i_candidate = 4'd0;
    i_rddata = 4'd0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rden", int'(o_rden), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_valid", int'(o_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty grid, centre cell
    run_req(4'd4, 4'd4, 4'd5, 0);
    chk("t1_done_cyc", done_cyc, 29);
    chk("t1_valid", valid_at_done, 1);
    chk("t1_busy_at_done", busy_at_done, 1);
    chk("t1_rden_cnt", rden_cnt, 27);
    chk("t1_first_rd", first_rd, 1);
    chk("t1_last_rd", last_rd, 27);
    chk("t1_addr_seq", addr_errs(27), 0);
    chk("t1_addr_zero", addr_zero_bad, 0);
    chk("t1_busy_after", busy_after, 0);
    chk("t1_valid_held", valid_after, 1);

    // Row conflict at k=7
    mem[43] = 4'd5;
    run_req(4'd4, 4'd4, 4'd5, 0);
    chk("t2_done_cyc", done_cyc, 10);
    chk("t2_valid", valid_at_done, 0);
    chk("t2_rden_cnt", rden_cnt, 9);
    chk("t2_last_rd", last_rd, 9);
    chk("t2_addr_seq", addr_errs(9), 0);
    chk("t2_addr_zero", addr_zero_bad, 0);

    // Own cell already holds the candidate; start pulse in the DONE cycle is ignored
    clear_mem();
    mem[20] = 4'd3;
    run_req(4'd2, 4'd2, 4'd3, 29);
    chk("t3_done_cyc", done_cyc, 29);
    chk("t3_valid", valid_at_done, 1);
    chk("t3_rden_cnt", rden_cnt, 27);
    chk("t3_start_in_done", busy_after, 0);

    // Box-only conflict at k=21
    clear_mem();
    mem[9] = 4'd9;
    run_req(4'd0, 4'd2, 4'd9, 0);
    chk("t4_done_cyc", done_cyc, 24);
    chk("t4_valid", valid_at_done, 0);
    chk("t4_rden_cnt", rden_cnt, 23);
    chk("t4_last_rd", last_rd, 23);

    // Out-of-range requests finish immediately without reads
    clear_mem();
    run_req(4'd1, 4'd1, 4'd1, 0);
    chk("t5_prep_valid", valid_at_done, 1);
    run_req(4'd4, 4'd4, 4'd10, 0);
    chk("t5a_done_cyc", done_cyc, 1);
    chk("t5a_valid", valid_at_done, 0);
    chk("t5a_rden_cnt", rden_cnt, 0);
    run_req(4'd4, 4'd4, 4'd0, 0);
    chk("t5b_done_cyc", done_cyc, 1);
    chk("t5b_rden_cnt", rden_cnt, 0);
    run_req(4'd9, 4'd4, 4'd5, 0);
    chk("t5c_done_cyc", done_cyc, 1);
    chk("t5c_valid", valid_at_done, 0);
    chk("t5c_rden_cnt", rden_cnt, 0);
    run_req(4'd4, 4'd9, 4'd5, 0);
    chk("t5d_done_cyc", done_cyc, 1);
    chk("t5d_rden_cnt", rden_cnt, 0);

    // Asynchronous reset in cycle 12 of a scan
    @(negedge clk);
    i_row = 4'd4; i_col = 4'd4; i_candidate = 4'd5; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("t6_pre_rden", int'(o_rden), 1);
    chk("t6_pre_busy", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rden", int'(o_rden), 0);
    chk("t6_rst_rdaddr", int'(o_rdaddr), 0);
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_done", int'(o_done), 0);
    chk("t6_rst_valid", int'(o_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_idle_busy", int'(o_busy), 0);
    chk("t6_idle_rden", int'(o_rden), 0);

    // Fresh scan after reset with an ignored start while busy
    run_req(4'd4, 4'd4, 4'd5, 5);
    chk("t7_done_cyc", done_cyc, 29);
    chk("t7_valid", valid_at_done, 1);
    chk("t7_rden_cnt", rden_cnt, 27);
    chk("t7_addr_seq", addr_errs(27), 0);
    chk("t7_busy_after", busy_after, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cand_checker.md
Name: cand_checker

Overview:
- Sequential legality checker directly downstream of the candidate generator (num_gen) in the backtracking solver.
- Takes the candidate digit num_gen produces for one cell and scans that cell's row, column and 3x3 box in the grid memory through a synchronous read port.
- Reports whether the digit may be written. The solver controller either commits the digit or re-enables num_gen for the next one.

Parameters:
- ADDR_W, 7, grid memory address width; fixed for the 81-cell grid, address = row*9 + col.
- DATA_W, 4, cell value width; 0 means empty, 1..9 are digits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request a check; sampled only in IDLE
- i_row  input  4  target cell row, 0..8
- i_col  input  4  target cell column, 0..8
- i_candidate  input  4  digit to test (num_gen o_wrdata)
- o_rden  output  1  grid memory read enable
- o_rdaddr  output  7  grid memory read address
- i_rddata  input  4  grid memory read data, valid exactly one cycle after o_rden/o_rdaddr
- o_busy  output  1  high in SCAN and DONE
- o_done  output  1  one-cycle pulse, result ready
- o_valid  output  1  1 = candidate legal; held from o_done until the next accepted start

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (asynchronous, any state including mid-scan):
  - FSM goes to IDLE; peer index, compare pipeline and latched inputs are cleared.
  - o_rden=0, o_rdaddr=0, o_busy=0, o_done=0, o_valid=0.
  - Any read data returning after reset is ignored.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - On i_start=1, latch i_row, i_col and i_candidate. The edge that samples i_start is E0, and cycle n is the n-th cycle after E0.
  - If the candidate is outside 1..9 (this includes num_gen's out-of-range value 10 and 0), or i_row>8, or i_col>8: go to DONE with result 0. o_done=1 in cycle 1. No reads are issued.
  - Otherwise go to SCAN with peer index k=0.
- SCAN, peer enumeration, k = 0..26:
  - k=0..8: cell (row, k).
  - k=9..17: cell (k-9, col).
  - k=18..26: with j=k-18, cell (br + j/3, bc + j%3), where br = row - row%3 and bc = col - col%3. Computed by lookup, no divider.
- Read pipeline:
  - Address for peer k is driven with o_rden=1 during cycle k+1.
  - Its data is compared during cycle k+2.
  - A one-bit pipeline flag marks an in-flight read, and a second flag marks a self-address (peer address == own address).
  - Self-address peers are never compared. There are 3 such reads: one each in the row, column and box groups.
- Conflict: a compared i_rddata == latched candidate.
  - On conflict, go to DONE with result 0. o_done=1 in cycle k+3.
  - o_rden drops from cycle k+3. The read already issued in cycle k+2 is discarded.
- No conflict after peer 26 is compared in cycle 28: go to DONE with result 1. o_done=1 in cycle 29.
- Empty peer cells (0) never conflict. Duplicate peers (a box cell shared with the row or column) are simply re-read.
- DONE:
  - Lasts one cycle. o_done=1 and o_valid is updated in that same cycle.
  - Then go to IDLE. o_done returns to 0, o_valid holds.
- o_busy=1 in SCAN and DONE.
- i_start while o_busy=1 is ignored and not queued. i_start in the same cycle that DONE returns to IDLE is also ignored; a new start is accepted from the first IDLE cycle.
- Input changes on i_row, i_col or i_candidate after acceptance have no effect.
- o_rdaddr=0 whenever o_rden=0.

Test Plan:
- Empty grid (all 0), start row=4 col=4 cand=5 -> o_rden asserted cycles 1..27 with addresses 36..44, 4..76 step 9, then 30,31,32,39,40,41,48,49,50; o_done in cycle 29; o_valid=1.
- Grid with cell (4,7)=5 (addr 43), start row=4 col=4 cand=5 -> conflict at k=7, o_done in cycle 10, o_valid=0, no o_rden from cycle 10.
- Own cell (2,2) already holds 3, no other 3 in its row/column/box, start row=2 col=2 cand=3 -> self reads skipped, o_valid=1 at cycle 29.
- Box-only conflict, cell (1,0)=9 and start row=0 col=2 cand=9 -> conflict at k=21 (addr 9), o_done in cycle 24, o_valid=0.
- cand=10 (num_gen out_of_range) or cand=0 or row=9 -> o_done in cycle 1, o_valid=0, o_rden never asserted.
- Assert rst_n=0 in cycle 12 of a full scan, then a second i_start during busy -> outputs zero immediately; busy-time start ignored; a fresh start after reset completes normally in 29 cycles.
